// File: rtl/cgra_sram_banked_wrapper.sv
// Word-interleaved multi-bank CGRA data memory with per-bank retention control.
// Each bank auto-enters retention when idle and wakes over a timed sequence.
module cgra_sram_banked_wrapper #(
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned NUM_WORDS       = 1024,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WAKE_CYCLES     = 4,
    parameter int unsigned IDLE_RET_CYCLES = 16,
    localparam int unsigned BankSel   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int unsigned AddrWidth = $clog2(NUM_BANKS * NUM_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [AddrWidth-1:0]    addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic [NUM_BANKS-1:0]    ret_req_i,
    output logic [NUM_BANKS-1:0]    bank_ret_o
);

    localparam int unsigned BankW    = (BankSel > 0) ? BankSel : 1;
    localparam int unsigned RowW     = AddrWidth - BankSel;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdleW    = $clog2(IDLE_RET_CYCLES + 2);
    localparam int unsigned WakeW    = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_RET    = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    logic [BankW-1:0]      w_bank;
    logic [RowW-1:0]       w_row;
    logic [NUM_BANKS-1:0]  w_bank_active;
    logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];
    logic                  r_rvalid;
    logic [BankW-1:0]      r_rbank;

    generate
        if (BankSel == 0) begin : g_one_bank
            assign w_bank = '0;
        end else begin : g_multi_bank
            assign w_bank = addr_i[BankSel-1:0];
        end
    endgenerate

    assign w_row = addr_i[AddrWidth-1:BankSel];

    // Reset gating keeps requests from being accepted while rst_ni is low.
    assign gnt_o = rst_ni & req_i & w_bank_active[w_bank]
                 & ~ret_req_i[w_bank];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        state_e                r_state;
        state_e                w_state_nxt;
        logic [IdleW-1:0]      r_idle;
        logic [IdleW-1:0]      w_idle_nxt;
        logic [WakeW-1:0]      r_wake;
        logic [WakeW-1:0]      w_wake_nxt;
        logic                  w_tgt;
        logic                  w_req;
        logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
        logic [DATA_WIDTH-1:0] r_rd;

        assign w_tgt = req_i & (w_bank == BankW'(b));
        assign w_req = gnt_o & (w_bank == BankW'(b));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= ST_ACTIVE;
                r_idle  <= '0;
                r_wake  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_idle  <= w_idle_nxt;
                r_wake  <= w_wake_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_idle_nxt  = r_idle;
            w_wake_nxt  = r_wake;
            unique case (r_state)
                ST_ACTIVE: begin
                    if (w_req) begin
                        w_idle_nxt = '0;
                    end else if (r_idle != IdleW'(IDLE_RET_CYCLES)) begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                    if (ret_req_i[b] || (IDLE_RET_CYCLES != 0 &&
                        r_idle == IdleW'(IDLE_RET_CYCLES) && !w_tgt)) begin
                        w_state_nxt = ST_RET;
                        w_idle_nxt  = '0;
                    end
                end
                ST_RET: begin
                    if (w_tgt && !ret_req_i[b]) begin
                        w_state_nxt = ST_WAKE;
                        w_wake_nxt  = '0;
                    end
                end
                ST_WAKE: begin
                    if (ret_req_i[b]) begin
                        w_state_nxt = ST_RET;
                        w_wake_nxt  = '0;
                    end else if (r_wake == WakeW'(WAKE_CYCLES - 1)) begin
                        w_state_nxt = ST_ACTIVE;
                        w_wake_nxt  = '0;
                        w_idle_nxt  = '0;
                    end else begin
                        w_wake_nxt = r_wake + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACTIVE;
                    w_idle_nxt  = '0;
                    w_wake_nxt  = '0;
                end
            endcase
        end

        // Storage has no reset; contents survive retention.
        always_ff @(posedge clk_i) begin
            if (w_req) begin
                if (we_i) begin
                    for (int i = 0; i < NumBytes; i++) begin
                        if (be_i[i]) begin
                            r_mem[w_row][8*i +: 8] <= wdata_i[8*i +: 8];
                        end
                    end
                end else begin
                    r_rd <= r_mem[w_row];
                end
            end
        end

        assign w_bank_active[b] = (r_state == ST_ACTIVE);
        assign bank_ret_o[b]    = (r_state == ST_RET);
        assign w_bank_rd[b]     = r_rd;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rbank  <= '0;
        end else begin
            r_rvalid <= gnt_o & ~we_i;
            if (gnt_o) begin
                r_rbank <= w_bank;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rvalid ? w_bank_rd[r_rbank] : '0;

endmodule
